ads127l01_ctrl: RTL and testbench
=================================

# ads127l01_ctrl

Power-up and run-time sequencer for the ADS127L01 ADC in hardware-pin, frame-sync, master mode. It drives the ADC control pins, including RESET, START and the OSR/FILTER/HR configuration. It gates the serial receiver's sample output through `rx_en` until the digital filter has settled. A frame watchdog restarts a stalled converter and latches a fault after repeated failures. It sits between system control/CSR logic and the ADC pins, alongside the receiver that produces the per-frame `frame_valid` pulse.

## Interface
- `RESET_LOW_CYC`, 64: clk cycles `reset_n` is held low per reset.
- `SETTLE_CYC`, 300: clk cycles after `reset_n` rises before `start` is asserted.
- `DISCARD_FRAMES`, 4: frames dropped after `start` rises (filter settling).
- `WDOG_CYC`, 4096: max clk cycles between frames in WARMUP/RUN.
- `MAX_RETRY`, 3: watchdog restarts allowed before FAULT.
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `en` in 1: enable; low forces IDLE.
- `cfg_osr` in 2: requested OSR pins.
- `cfg_filter` in 2: requested FILTER pins.
- `cfg_hr` in 1: requested HR pin.
- `cfg_update` in 1: one-cycle pulse; apply the `cfg_*` inputs.
- `frame_valid` in 1: one-cycle pulse per received frame (from the receiver).
- `reset_n`, `start`, `hr` out 1: ADC pins, registered.
- `osr`, `filter` out 2: ADC pins, registered.
- `fsmode`, `format`, `cs_n`, `din`, `daisy_in` out 1: constants 1, 1, 0, 0, 0.
- `rx_en` out 1: receiver output enable; high only in RUN.
- `running` out 1: high in RUN.
- `fault` out 1: high in FAULT.
- `state` out 3: IDLE=0, RESET=1, SETTLE=2, WARMUP=3, RUN=4, FAULT=5.
- `retry_cnt` out 2: watchdog restarts since the last RUN entry; saturating.

## Operation
- **Reset values:** state IDLE, `reset_n`=0, `start`=0, `osr`=00, `filter`=01, `hr`=1, `rx_en`=0, `running`=0, `fault`=0, `retry_cnt`=0.
  - The shadow config resets to 00 / 01 / 1.
  - Resetting mid-operation returns to these values on the next edge.
- **IDLE:** `reset_n`=0, `start`=0. If `en`=1, go to RESET.
- **RESET:** `reset_n`=0 for exactly `RESET_LOW_CYC` cycles, then go to SETTLE.
  - Pins `osr`/`filter`/`hr` load from the shadow config on entry to RESET, in the same edge that `reset_n` goes low.
  - Config pins never change while `reset_n`=1.
- **SETTLE:** `reset_n`=1, `start`=0 for `SETTLE_CYC` cycles, then go to WARMUP.
- **WARMUP:** `start`=1. Count `frame_valid` pulses. On the `DISCARD_FRAMES`-th pulse, go to RUN and clear `retry_cnt`.
- **RUN:** `start`=1, `rx_en`=1, `running`=1.
- **Watchdog** (WARMUP and RUN only):
  - The counter clears on entering either state and on every `frame_valid`.
  - On reaching `WDOG_CYC`: if `retry_cnt` < `MAX_RETRY`, increment it and go to RESET; otherwise go to FAULT.
- **FAULT:** `reset_n`=0, `start`=0, `fault`=1. Left only via `en`=0 (to IDLE) or `rst`. `cfg_update` is ignored.
- **`cfg_update`** in any state except FAULT:
  - Latch `cfg_*` into the shadow config.
  - In RESET/SETTLE/WARMUP/RUN, re-enter RESET (the counter restarts) without incrementing `retry_cnt`.
  - In IDLE, only the shadow is updated.
- **Priority in the same cycle:** `en`=0 > `cfg_update` > `frame_valid` > watchdog expiry. A frame arriving on the expiry cycle prevents the restart.

## Timing
- All outputs are registered; state changes take effect on the edge after the triggering input.
- **From `en` rise in IDLE:**
  - `reset_n` stays low through cycles 1..`RESET_LOW_CYC`.
  - `reset_n` rises at cycle `RESET_LOW_CYC`+1.
  - `start` rises at cycle `RESET_LOW_CYC`+`SETTLE_CYC`+1.
- **`rx_en`:** rises the cycle after the `DISCARD_FRAMES`-th `frame_valid`. It falls the cycle after `en`=0, `cfg_update`, or watchdog expiry.
- **`en`=0:** IDLE, with `reset_n`=0 and `start`=0, one edge later from any state.
- **Watchdog expiry:** fires exactly `WDOG_CYC` cycles after the last frame (or after state entry) with no intervening `frame_valid`.

## Test plan
All scenarios use `RESET_LOW_CYC`=4, `SETTLE_CYC`=8, `DISCARD_FRAMES`=2, `WDOG_CYC`=32, `MAX_RETRY`=2.

1. **Power-up:** `rst` for 5 cycles, then `en`=1, then `frame_valid` every 16 cycles.
   - `reset_n` low 4 cycles, then high.
   - `start`=1 eight cycles later.
   - `rx_en`=1 one cycle after the 2nd frame; `state`=4.
2. **Config change in RUN:** `cfg_osr`=10, `cfg_filter`=00, `cfg_hr`=0 with a `cfg_update` pulse.
   - Next edge: `rx_en`=0, `reset_n`=0, pins 10 / 00 / 0; `retry_cnt` unchanged.
   - Full sequence then repeats.
3. **Watchdog recovery:** stop frames in RUN.
   - After 32 cycles: RESET, `retry_cnt`=1.
   - Resume frames: reaches RUN, `retry_cnt`=0.
4. **Fault:** never send frames after `start`.
   - Retries reach 2, then FAULT with `fault`=1 and `reset_n`=0.
   - `cfg_update` is ignored; `en`=0 gives IDLE with `fault`=0.
5. **Collision:** `frame_valid` on the exact expiry cycle keeps RUN. `cfg_update` together with expiry gives RESET with `retry_cnt` unchanged.
6. **Reset mid-WARMUP:** `rst`=1 for one cycle. All outputs return to reset values the next cycle; IDLE, then restart while `en`=1.

Source files
------------

// File: rtl/ads127l01_ctrl.sv
// Power-up / run-time sequencer for the ADS127L01 (hardware-pin, frame-sync master mode).
// Latency: every output is registered, so a state change is visible one clk after the input that causes it.
// Backpressure: none; frame_valid is a one-cycle pulse that is never stalled; rx_en gates the receiver.
module ads127l01_ctrl #(
    parameter int RESET_LOW_CYC  = 64,
    parameter int SETTLE_CYC     = 300,
    parameter int DISCARD_FRAMES = 4,
    parameter int WDOG_CYC       = 4096,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] cfg_osr,
    input  logic [1:0] cfg_filter,
    input  logic       cfg_hr,
    input  logic       cfg_update,
    input  logic       frame_valid,
    output logic       reset_n,
    output logic       start,
    output logic       hr,
    output logic [1:0] osr,
    output logic [1:0] filter,
    output logic       fsmode,
    output logic       format,
    output logic       cs_n,
    output logic       din,
    output logic       daisy_in,
    output logic       rx_en,
    output logic       running,
    output logic       fault,
    output logic [2:0] state,
    output logic [1:0] retry_cnt
);

    localparam int PH_MAX = (RESET_LOW_CYC > SETTLE_CYC) ? RESET_LOW_CYC : SETTLE_CYC;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int WD_W   = $clog2(WDOG_CYC + 1);
    localparam int FR_W   = $clog2(DISCARD_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RESET  = 3'd1,
        S_SETTLE = 3'd2,
        S_WARMUP = 3'd3,
        S_RUN    = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t            cur_state;
    state_t            nxt_state;
    logic [PH_W-1:0]   ph_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic [FR_W-1:0]   fr_cnt;
    logic [1:0]        retry_q;
    logic [1:0]        retry_nxt;
    logic [4:0]        shadow;
    logic [4:0]        shadow_nxt;
    logic              restart;
    logic              entering;
    logic              wd_active;
    logic              wd_expire;

    assign fsmode    = 1'b1;
    assign format    = 1'b1;
    assign cs_n      = 1'b0;
    assign din       = 1'b0;
    assign daisy_in  = 1'b0;
    assign state     = cur_state;
    assign retry_cnt = retry_q;

    assign wd_active = (cur_state == S_WARMUP) || (cur_state == S_RUN);
    assign wd_expire = wd_active && (wd_cnt == WD_W'(WDOG_CYC - 1));

    always_comb begin
        nxt_state  = cur_state;
        retry_nxt  = retry_q;
        shadow_nxt = shadow;
        restart    = 1'b0;

        if (cfg_update && cur_state != S_FAULT) begin
            shadow_nxt = {cfg_osr, cfg_filter, cfg_hr};
        end

        if (!en) begin
            nxt_state = S_IDLE;
        end else if (cfg_update && cur_state != S_IDLE && cur_state != S_FAULT) begin
            // Config change restarts the ADC so new pins are sampled under reset.
            nxt_state = S_RESET;
            restart   = 1'b1;
        end else begin
            case (cur_state)
                S_IDLE: nxt_state = S_RESET;
                S_RESET: begin
                    if (ph_cnt == PH_W'(RESET_LOW_CYC - 1)) nxt_state = S_SETTLE;
                end
                S_SETTLE: begin
                    if (ph_cnt == PH_W'(SETTLE_CYC - 1)) nxt_state = S_WARMUP;
                end
                S_WARMUP, S_RUN: begin
                    if (frame_valid) begin
                        if (cur_state == S_WARMUP && fr_cnt == FR_W'(DISCARD_FRAMES - 1)) begin
                            nxt_state = S_RUN;
                            retry_nxt = 2'd0;
                        end
                    end else if (wd_expire) begin
                        if (int'(retry_q) < MAX_RETRY && retry_q != 2'd3) begin
                            retry_nxt = retry_q + 2'd1;
                            nxt_state = S_RESET;
                        end else begin
                            nxt_state = S_FAULT;
                        end
                    end
                end
                S_FAULT: nxt_state = S_FAULT;
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    assign entering = (nxt_state != cur_state) || restart;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_IDLE;
            ph_cnt    <= '0;
            wd_cnt    <= '0;
            fr_cnt    <= '0;
            retry_q   <= 2'd0;
            shadow    <= 5'b00_01_1;
            reset_n   <= 1'b0;
            start     <= 1'b0;
            rx_en     <= 1'b0;
            running   <= 1'b0;
            fault     <= 1'b0;
            osr       <= 2'b00;
            filter    <= 2'b01;
            hr        <= 1'b1;
        end else begin
            cur_state <= nxt_state;
            retry_q   <= retry_nxt;
            shadow    <= shadow_nxt;

            if (entering) begin
                ph_cnt <= '0;
            end else if (cur_state == S_RESET || cur_state == S_SETTLE) begin
                ph_cnt <= ph_cnt + PH_W'(1);
            end

            if (entering || frame_valid) begin
                wd_cnt <= '0;
            end else if (wd_active) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end

            if (entering) begin
                fr_cnt <= '0;
            end else if (cur_state == S_WARMUP && frame_valid) begin
                fr_cnt <= fr_cnt + FR_W'(1);
            end

            reset_n <= (nxt_state == S_SETTLE) || (nxt_state == S_WARMUP) || (nxt_state == S_RUN);
            start   <= (nxt_state == S_WARMUP) || (nxt_state == S_RUN);
            rx_en   <= (nxt_state == S_RUN);
            running <= (nxt_state == S_RUN);
            fault   <= (nxt_state == S_FAULT);

            // Config pins only move on the edge that drives reset_n low.
            if (entering && nxt_state == S_RESET) begin
                {osr, filter, hr} <= shadow_nxt;
            end
        end
    end

endmodule

// File: tb/tb_ads127l01_ctrl.sv
// Bench for ads127l01_ctrl: expectations are queued with a target cycle and compared when that cycle's outputs settle.
module tb_ads127l01_ctrl;

    localparam int F_STATE = 0, F_RSTN = 1, F_START = 2, F_RXEN = 3, F_RUN = 4, F_FAULT = 5,
                   F_RETRY = 6, F_OSR = 7, F_FILT = 8, F_HR = 9, F_CONST = 10;

    logic       clk = 1'b0;
    logic       rst, en, cfg_hr, cfg_update, frame_valid;
    logic [1:0] cfg_osr, cfg_filter;
    logic       reset_n, start, hr, fsmode, format, cs_n, din, daisy_in;
    logic       rx_en, running, fault;
    logic [1:0] osr, filter, retry_cnt;
    logic [2:0] state;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         cyc;
        int         sel;
        logic [7:0] val;
    } exp_t;
    exp_t sb[$];

    ads127l01_ctrl #(
        .RESET_LOW_CYC (4),
        .SETTLE_CYC    (8),
        .DISCARD_FRAMES(2),
        .WDOG_CYC      (32),
        .MAX_RETRY     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .cfg_osr    (cfg_osr),
        .cfg_filter (cfg_filter),
        .cfg_hr     (cfg_hr),
        .cfg_update (cfg_update),
        .frame_valid(frame_valid),
        .reset_n    (reset_n),
        .start      (start),
        .hr         (hr),
        .osr        (osr),
        .filter     (filter),
        .fsmode     (fsmode),
        .format     (format),
        .cs_n       (cs_n),
        .din        (din),
        .daisy_in   (daisy_in),
        .rx_en      (rx_en),
        .running    (running),
        .fault      (fault),
        .state      (state),
        .retry_cnt  (retry_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic string fname(input int sel);
        case (sel)
            F_STATE: return "state";
            F_RSTN:  return "reset_n";
            F_START: return "start";
            F_RXEN:  return "rx_en";
            F_RUN:   return "running";
            F_FAULT: return "fault";
            F_RETRY: return "retry_cnt";
            F_OSR:   return "osr";
            F_FILT:  return "filter";
            F_HR:    return "hr";
            default: return "const_pins";
        endcase
    endfunction

    function automatic logic [7:0] actual(input int sel);
        case (sel)
            F_STATE: return {5'd0, state};
            F_RSTN:  return {7'd0, reset_n};
            F_START: return {7'd0, start};
            F_RXEN:  return {7'd0, rx_en};
            F_RUN:   return {7'd0, running};
            F_FAULT: return {7'd0, fault};
            F_RETRY: return {6'd0, retry_cnt};
            F_OSR:   return {6'd0, osr};
            F_FILT:  return {6'd0, filter};
            F_HR:    return {7'd0, hr};
            default: return {3'd0, fsmode, format, cs_n, din, daisy_in};
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check($sformatf("%s@%0d", fname(sb[i].sel), cyc), 16'(actual(sb[i].sel)), 16'(sb[i].val));
                sb.delete(i);
            end
        end
    end

    task automatic exp_at(input int dc, input int sel, input logic [7:0] val);
        exp_t e;
        e.cyc = cyc + dc;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_valid = 1'b1;
        tick();
        frame_valid = 1'b0;
    endtask

    // Called on the cycle WARMUP is entered; two frames 16 cycles apart bring it to RUN.
    task automatic warm_to_run();
        repeat (15) tick();
        exp_at(1, F_STATE, 3);
        exp_at(1, F_RXEN, 0);
        pulse_frame();
        repeat (15) tick();
        exp_at(0, F_RXEN, 0);
        exp_at(1, F_RXEN, 1);
        exp_at(1, F_STATE, 4);
        exp_at(1, F_RUN, 1);
        exp_at(1, F_START, 1);
        exp_at(1, F_RETRY, 0);
        pulse_frame();
    endtask

    task automatic exp_reset_values(input int dc);
        exp_at(dc, F_STATE, 0);
        exp_at(dc, F_RSTN, 0);
        exp_at(dc, F_START, 0);
        exp_at(dc, F_OSR, 0);
        exp_at(dc, F_FILT, 1);
        exp_at(dc, F_HR, 1);
        exp_at(dc, F_RXEN, 0);
        exp_at(dc, F_RUN, 0);
        exp_at(dc, F_FAULT, 0);
        exp_at(dc, F_RETRY, 0);
        exp_at(dc, F_CONST, 8'b0001_1000);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; cfg_osr = 2'b00; cfg_filter = 2'b00; cfg_hr = 1'b0;
        cfg_update = 1'b0; frame_valid = 1'b0;

        // Power-up
        repeat (5) tick();
        exp_reset_values(0);
        rst = 1'b0;
        en  = 1'b1;
        exp_at(1, F_STATE, 1);
        exp_at(1, F_RSTN, 0);
        exp_at(4, F_RSTN, 0);
        exp_at(5, F_RSTN, 1);
        exp_at(5, F_STATE, 2);
        exp_at(12, F_START, 0);
        exp_at(13, F_START, 1);
        exp_at(13, F_STATE, 3);
        exp_at(13, F_RXEN, 0);
        tick();
        repeat (12) tick();
        warm_to_run();
        repeat (15) tick();
        exp_at(1, F_STATE, 4);
        pulse_frame();

        // Config change in RUN
        cfg_osr = 2'b10; cfg_filter = 2'b00; cfg_hr = 1'b0; cfg_update = 1'b1;
        exp_at(0, F_OSR, 0);
        exp_at(1, F_RXEN, 0);
        exp_at(1, F_RSTN, 0);
        exp_at(1, F_STATE, 1);
        exp_at(1, F_OSR, 2);
        exp_at(1, F_FILT, 0);
        exp_at(1, F_HR, 0);
        exp_at(1, F_RETRY, 0);
        exp_at(5, F_RSTN, 1);
        exp_at(13, F_START, 1);
        exp_at(13, F_OSR, 2);
        tick();
        cfg_update = 1'b0;
        repeat (12) tick();
        warm_to_run();

        // Watchdog recovery
        exp_at(31, F_STATE, 4);
        exp_at(32, F_STATE, 1);
        exp_at(32, F_RETRY, 1);
        exp_at(32, F_RXEN, 0);
        exp_at(32, F_RSTN, 0);
        exp_at(43, F_RETRY, 1);
        repeat (32) tick();
        repeat (12) tick();
        exp_at(0, F_STATE, 3);
        warm_to_run();

        // Fault after repeated watchdog restarts
        exp_at(32, F_RETRY, 1);
        exp_at(76, F_STATE, 1);
        exp_at(76, F_RETRY, 2);
        exp_at(88, F_STATE, 3);
        exp_at(119, F_STATE, 3);
        exp_at(120, F_STATE, 5);
        exp_at(120, F_FAULT, 1);
        exp_at(120, F_RSTN, 0);
        exp_at(120, F_START, 0);
        exp_at(120, F_RETRY, 2);
        repeat (120) tick();
        cfg_osr = 2'b01; cfg_filter = 2'b11; cfg_hr = 1'b1; cfg_update = 1'b1;
        exp_at(1, F_STATE, 5);
        exp_at(1, F_OSR, 2);
        exp_at(1, F_FAULT, 1);
        tick();
        cfg_update = 1'b0;
        en = 1'b0;
        exp_at(1, F_STATE, 0);
        exp_at(1, F_FAULT, 0);
        exp_at(1, F_RSTN, 0);
        exp_at(1, F_START, 0);
        tick();
        en = 1'b1;
        exp_at(1, F_STATE, 1);
        exp_at(1, F_OSR, 2);
        exp_at(1, F_FILT, 0);
        exp_at(1, F_HR, 0);
        tick();
        repeat (12) tick();
        exp_at(0, F_STATE, 3);
        warm_to_run();

        // Collisions with watchdog expiry
        repeat (31) tick();
        exp_at(1, F_STATE, 4);
        exp_at(1, F_RXEN, 1);
        pulse_frame();
        repeat (31) tick();
        cfg_osr = 2'b01; cfg_filter = 2'b10; cfg_hr = 1'b1; cfg_update = 1'b1;
        exp_at(1, F_STATE, 1);
        exp_at(1, F_RETRY, 0);
        exp_at(1, F_RXEN, 0);
        exp_at(1, F_RSTN, 0);
        exp_at(1, F_OSR, 1);
        exp_at(1, F_FILT, 2);
        exp_at(1, F_HR, 1);
        tick();
        cfg_update = 1'b0;
        repeat (12) tick();
        exp_at(0, F_STATE, 3);
        exp_at(0, F_RETRY, 0);

        // Synchronous reset mid-WARMUP, then restart with en still high
        repeat (5) tick();
        rst = 1'b1;
        exp_reset_values(1);
        tick();
        rst = 1'b0;
        exp_at(1, F_STATE, 1);
        exp_at(1, F_OSR, 0);
        exp_at(1, F_FILT, 1);
        exp_at(1, F_HR, 1);
        exp_at(5, F_RSTN, 1);
        exp_at(13, F_START, 1);
        tick();
        repeat (12) tick();
        warm_to_run();

        repeat (2) tick();
        check("sb_empty", 16'(sb.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
